// File: rtl/rv32i_rf_wb_arbiter.sv
// Round-robin write-back arbiter for the RV32I register-file write port.
// Define RV32I_RF_CLEAR_EN to zero x1..x(NUM_OF_SETS-1) after reset before accepting traffic.
module rv32i_rf_wb_arbiter #(
    parameter int NUM_OF_SETS    = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int NUM_REQ        = 3,
    localparam int AW = $clog2(NUM_OF_SETS),
    localparam int DW = DATA_BUS_WIDTH,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rf_wr_enable,
    output logic [AW-1:0]         rf_wr_addr,
    output logic [DW-1:0]         rf_wr_data,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    logic [AW-1:0] addr_arr [NUM_REQ];
    logic [DW-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    logic          run;
    logic          clr_wr;
    logic [AW-1:0] clr_addr;

`ifdef RV32I_RF_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [AW:0] CLR_END = (AW+1)'(NUM_OF_SETS);

    state_t      state, state_nxt;
    logic [AW:0] clr_ptr, clr_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= (AW+1)'(1);
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // clr_ptr runs one past the last address so the final clear write
    // drains before RUN can accept a request.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_wr      = 1'b0;
        if (state == CLEAR) begin
            if (clr_ptr < CLR_END) begin
                clr_wr      = 1'b1;
                clr_ptr_nxt = clr_ptr + 1'b1;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    assign clr_addr = clr_ptr[AW-1:0];
    assign run      = (state == RUN);
    assign busy     = (state == CLEAR);
`else
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
    assign run      = 1'b1;
    assign busy     = 1'b0;
`endif

    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner;
    logic [GW-1:0] cand;
    logic          found;
    logic          hs;

    // Scan starts just past the previous winner, wrapping around.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + 1 + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        hs        = run && found;
        req_ready = '0;
        if (hs) req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_enable <= 1'b0;
            rf_wr_addr   <= '0;
            rf_wr_data   <= '0;
            grant_id     <= '0;
            last_grant   <= GW'(NUM_REQ - 1);
        end else begin
            rf_wr_enable <= 1'b0;
            if (clr_wr) begin
                rf_wr_enable <= 1'b1;
                rf_wr_addr   <= clr_addr;
                rf_wr_data   <= '0;
            end else if (hs) begin
                // x0 requests still consume the grant but never write
                rf_wr_enable <= (addr_arr[winner] != '0);
                rf_wr_addr   <= addr_arr[winner];
                rf_wr_data   <= data_arr[winner];
                grant_id     <= winner;
                last_grant   <= winner;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_rf_wb_arbiter.sv
// Randomised bench for rv32i_rf_wb_arbiter against a behavioural arbitration/clear model.
module tb_rv32i_rf_wb_arbiter;
    localparam int NS = 32;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int AW = $clog2(NS);
    localparam int GW = $clog2(NR);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR*AW-1:0]   req_addr = '0;
    logic [NR*DW-1:0]   req_data = '0;
    logic [NR-1:0]      req_ready;
    logic               rf_wr_enable;
    logic [AW-1:0]      rf_wr_addr;
    logic [DW-1:0]      rf_wr_data;
    logic [GW-1:0]      grant_id;
    logic               busy;

    rv32i_rf_wb_arbiter #(.NUM_OF_SETS(NS), .DATA_BUS_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .rf_wr_enable(rf_wr_enable),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef RV32I_RF_CLEAR_EN
    localparam int CLR_START = 0;
`else
    localparam int CLR_START = NS;
`endif

    int n_chk = 0;
    int n_pass = 0;

    // model state: expected registered outputs, last grant, clear progress
    int          m_last;
    int          m_clr;
    logic        e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int          e_gid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outs();
        chk("wr_enable", rf_wr_enable, e_en);
        chk("wr_addr", rf_wr_addr, e_addr);
        chk("wr_data", rf_wr_data, e_data);
        chk("grant_id", grant_id, e_gid);
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic do_reset(input logic [NR-1:0] v);
        rst = 1'b1;
        req_valid = v;
        @(posedge clk); #1;
        m_last = NR - 1; m_clr = CLR_START;
        e_en = 1'b0; e_addr = '0; e_data = '0; e_gid = 0;
        check_outs();
        chk("busy_rst", busy, m_clr < NS);
        rst = 1'b0;
    endtask

    task automatic cycle(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                         input logic [NR*DW-1:0] d);
        int w;
        logic [NR-1:0] er;
        req_valid = v; req_addr = a; req_data = d;
        #2;
        w = -1; er = '0;
        if (m_clr >= NS)
            for (int k = 1; k <= NR; k++)
                if (w < 0 && v[(m_last + k) % NR]) w = (m_last + k) % NR;
        if (w >= 0) er[w] = 1'b1;
        chk("ready", req_ready, er);
        chk("busy", busy, m_clr < NS);
        @(posedge clk); #1;
        if (m_clr < NS - 1) begin
            e_en = 1'b1; e_addr = AW'(m_clr + 1); e_data = '0; m_clr++;
        end else if (m_clr == NS - 1) begin
            e_en = 1'b0; m_clr++;
        end else if (w >= 0) begin
            e_addr = a[w*AW +: AW]; e_data = d[w*DW +: DW];
            e_en = (e_addr != '0); e_gid = w; m_last = w;
        end else begin
            e_en = 1'b0;
        end
        check_outs();
    endtask

    task automatic rand_cycle(input logic [NR-1:0] v);
        logic [NR*AW-1:0] a;
        logic [NR*DW-1:0] d;
        for (int i = 0; i < NR; i++) begin
            a[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            d[i*DW +: DW] = DW'($urandom);
        end
        cycle(v, a, d);
    endtask

    task automatic finish_clear();
        while (m_clr < NS) rand_cycle('1);
    endtask

    logic [NR*AW-1:0] a;
    logic [NR*DW-1:0] d;

    initial begin
        do_reset('0);
`ifdef RV32I_RF_CLEAR_EN
        for (int i = 0; i < 11; i++) rand_cycle('1);
        do_reset('1);
        finish_clear();
`endif
        // first request after reset: requester 0, addr 7
        a = '0; d = '0;
        a[0 +: AW] = 7; d[0 +: DW] = 32'h55;
        cycle(3'b001, a, d);
        chk("first_wr_addr", rf_wr_addr, 7);

        // single requester 1
        a = '0; d = '0;
        a[AW +: AW] = 5; d[DW +: DW] = 32'hDEADBEEF;
        cycle(3'b010, a, d);
        chk("single_gid", grant_id, 1);
        chk("single_data", rf_wr_data, 32'hDEADBEEF);

        // round robin from fresh reset: expect 0,1,2,0,1,2
        do_reset('0);
        finish_clear();
        for (int i = 0; i < 6; i++) begin
            rand_cycle(3'b111);
            chk("rr_order", grant_id, i % NR);
        end

        // x0 request consumes the grant without writing
        a = '0; d = '0;
        d[2*DW +: DW] = 32'h1234;
        cycle(3'b100, a, d);
        chk("x0_no_write", rf_wr_enable, 1'b0);
        rand_cycle(3'b111);
        chk("x0_next_prio", grant_id, 0);

        // random traffic
        for (int i = 0; i < 400; i++) rand_cycle(NR'($urandom));

        // reset during sustained traffic cancels the pending write
        rand_cycle('1);
        do_reset('1);
        finish_clear();
        for (int i = 0; i < 100; i++) rand_cycle(NR'($urandom));
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rv32i_rf_wb_arbiter.md
# rv32i_rf_wb_arbiter

Write-back arbiter and initialiser for the RV32I register file's single synchronous write port. Collects write-back requests from up to NUM_REQ sources (ALU, load unit, CSR/debug) over valid/ready handshakes, grants one per cycle round-robin, and drives registered write-enable, address and data into the register file. It can optionally sequence a post-reset clear of x1..x31 before accepting traffic.

## Interface
- NUM_OF_SETS, 32, register count; address width AW = $clog2(NUM_OF_SETS)
- DATA_BUS_WIDTH, 32, data width DW
- NUM_REQ, 3, requester count (2..8); requester 0 is the ALU write-back
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*AW  flattened destination addresses; requester i at [i*AW +: AW]
- req_data  in  NUM_REQ*DW  flattened write data; requester i at [i*DW +: DW]
- req_ready  out  NUM_REQ  one-hot-or-zero accept; combinational from req_valid and state
- rf_wr_enable  out  1  register-file write enable, registered
- rf_wr_addr  out  AW  register-file write address, registered
- rf_wr_data  out  DW  register-file write data, registered
- grant_id  out  $clog2(NUM_REQ)  index of requester driving current rf_wr_*, registered
- busy  out  1  high while clearing; no request accepted

## Operation
- States: CLEAR and RUN. Reset enters CLEAR (macro defined) or RUN (macro undefined).
- CLEAR: counter clr_ptr starts at 1 and increments each cycle; writes zero to address clr_ptr. After address NUM_OF_SETS-1 is written, the block enters RUN. req_ready = 0 throughout.
- RUN: the winner is the lowest index at or above (last_grant+1) mod NUM_REQ with req_valid set, scanning with wrap-around. req_ready[winner] = 1; all other bits = 0. last_grant updates to winner only on a handshake.
- A handshake (valid & ready) registers req_addr and req_data of the winner into rf_wr_addr/rf_wr_data, and the winner index into grant_id.
- Address 0 request: handshake completes and last_grant advances, but rf_wr_enable = 0 that cycle. x0 is never written.
- No valid request: rf_wr_enable = 0. rf_wr_addr, rf_wr_data and grant_id hold their previous values.
- Requesters must hold addr and data stable while valid and not ready. Dropping valid before ready is permitted; the request is lost without side effect.
- Two requesters targeting the same address in consecutive cycles produce two writes in grant order. The last one wins.

## Timing
- Reset values: rf_wr_enable=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 has first priority), clr_ptr=1. busy=1 with the macro, 0 without it.
- Latency: a handshake at edge N drives rf_wr_* after edge N. The register file captures the write at edge N+1. Read-after-write is visible after edge N+1.
- Throughput: one write per cycle. Under sustained contention, each requester waits at most NUM_REQ-1 grants.
- Clear timing: let E0 be the first edge with rst=0. After E0+k (k=0..NUM_OF_SETS-2), rf_wr_enable=1, addr=k+1, data=0. After E0+NUM_OF_SETS-1, busy=0, state=RUN, and req_ready may assert. rf_wr_enable=0 in that cycle unless a handshake at that edge was impossible, which it was.
- Reset asserted mid-clear or mid-traffic: the next edge restores reset values, and any in-flight registered write is cancelled (rf_wr_enable=0). With the macro, the clear restarts from address 1.

## Configuration
- RV32I_RF_CLEAR_EN defined: the CLEAR state and clr_ptr exist. busy behaves as above, and the register file holds zeros before the first accepted request.
- RV32I_RF_CLEAR_EN undefined: no CLEAR state, and busy is tied to 0. RUN starts at the first edge after reset. Register contents are undefined until written.

## Test plan
- Clear (macro on): release rst, hold all req_valid=1 -> 31 consecutive writes with addr 1..31 and data 0, all req_ready=0, busy falls after E0+31. Then req_ready=3'b001 in the first RUN cycle.
- Single requester: req_valid=3'b010, addr=5, data=0xDEADBEEF -> req_ready=3'b010. The next cycle shows rf_wr_enable=1, addr=5, data=0xDEADBEEF, grant_id=1.
- Round-robin: req_valid=3'b111 held for 6 cycles, with each requester re-presenting after its grant -> grant_id sequence 0,1,2,0,1,2.
- x0 drop: requester 2 valid with addr=0, data=0x1234 -> req_ready[2]=1, the next cycle rf_wr_enable=0, and requester 0 has priority next.
- Reset mid-clear: assert rst for one cycle at E0+10 -> rf_wr_enable=0 after that edge, and the clear restarts with addr 1 and runs 31 writes.
- Macro off: release rst with req_valid=3'b001, addr=7, data=0x55 -> req_ready=1 at E0, busy=0 always, and the write appears after E0.
